// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared owner/state encodings and default arbiter constants
package mem_arbiter_pkg;
    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int STARVE_MAX_DEF = 3;
    localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester (IF, LS) and memory-side signal bundle
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic if_req;
    logic [ADDR_W-1:0] if_addr;
    logic if_gnt;
    logic if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic if_err;
    logic ls_req;
    logic ls_we;
    logic [DATA_W/8-1:0] ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic ls_gnt;
    logic ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic ls_err;
    logic mem_req;
    logic mem_we;
    logic [DATA_W/8-1:0] mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    modport slave (
        input if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_ready, mem_rdata,
        input if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_guard.sv
// mem_arbiter_rr_guard: LS-priority grant select with saturating IF starvation counter
module mem_arbiter_rr_guard
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_i,
    input  logic   if_req_i,
    input  logic   ls_req_i,
    output logic   gnt_o,
    output owner_e win_o
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // LS wins ties until IF has been passed over STARVE_MAX times in a row
    always_comb begin
        gnt_o = en_i && (if_req_i || ls_req_i);
        win_o = (ls_req_i && !(if_req_i && cnt_q == CW'(STARVE_MAX))) ? OWN_LS : OWN_IF;
        cnt_d = cnt_q;
        if (gnt_o && win_o == OWN_IF) cnt_d = '0;
        else if (gnt_o && if_req_i && cnt_q != CW'(STARVE_MAX)) cnt_d = cnt_q + CW'(1);
    end
    // starvation counter register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between IF and LS with timeout protection
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic clk,
    input logic rst_n,
    mem_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_e state_q, state_d;
    owner_e owner_q, owner_d, win;
    logic [TW-1:0] tmo_q, tmo_d;
    logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
    logic ls_rvalid_q, ls_rvalid_d, ls_err_q, ls_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d, rsp_data;
    logic arb_en, grant, done, tmo_hit;

    assign arb_en = rst_n && (state_q == S_IDLE || bus.mem_ready);

    mem_arbiter_rr_guard #(.STARVE_MAX(STARVE_MAX)) u_guard (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (arb_en),
        .if_req_i (bus.if_req),
        .ls_req_i (bus.ls_req),
        .gnt_o    (grant),
        .win_o    (win)
    );

    // next state: completion/timeout response, then optional back-to-back grant
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        tmo_d = tmo_q;
        mem_req_d = mem_req_q;
        mem_we_d = mem_we_q;
        mem_be_d = mem_be_q;
        mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        done = state_q == S_BUSY && bus.mem_ready;
        tmo_hit = state_q == S_BUSY && !bus.mem_ready && tmo_q == TW'(TIMEOUT);
        rsp_data = (tmo_hit || mem_we_q) ? '0 : bus.mem_rdata;
        if_rvalid_d = (done || tmo_hit) && owner_q == OWN_IF;
        ls_rvalid_d = (done || tmo_hit) && owner_q == OWN_LS;
        if_err_d = tmo_hit && owner_q == OWN_IF;
        ls_err_d = tmo_hit && owner_q == OWN_LS;
        if (if_rvalid_d) if_rdata_d = rsp_data;
        if (ls_rvalid_d) ls_rdata_d = rsp_data;
        if (state_q == S_BUSY && !bus.mem_ready && !tmo_hit) tmo_d = tmo_q + TW'(1);
        if (grant) begin
            state_d = S_BUSY;
            owner_d = win;
            tmo_d = '0;
            mem_req_d = 1'b1;
            mem_we_d = win == OWN_LS ? bus.ls_we : 1'b0;
            mem_be_d = win == OWN_LS ? bus.ls_be : '1;
            mem_addr_d = win == OWN_LS ? bus.ls_addr : bus.if_addr;
            mem_wdata_d = win == OWN_LS ? bus.ls_wdata : '0;
        end else if (done || tmo_hit) begin
            state_d = S_IDLE;
            mem_req_d = 1'b0;
        end
    end

    // state and output registers; reset drops any in-flight transaction silently
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            tmo_q <= '0;
            mem_req_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_be_q <= '0;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_err_q <= 1'b0;
            if_rdata_q <= '0;
            ls_rvalid_q <= 1'b0;
            ls_err_q <= 1'b0;
            ls_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            tmo_q <= tmo_d;
            mem_req_q <= mem_req_d;
            mem_we_q <= mem_we_d;
            mem_be_q <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_err_q <= if_err_d;
            if_rdata_q <= if_rdata_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_err_q <= ls_err_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign bus.if_gnt = grant && win == OWN_IF;
    assign bus.ls_gnt = grant && win == OWN_LS;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_err = if_err_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_err = ls_err_q;
    assign bus.ls_rdata = ls_rdata_q;
    assign bus.mem_req = mem_req_q;
    assign bus.mem_we = mem_we_q;
    assign bus.mem_be = mem_be_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector check of grant order, back-to-back, timeout and reset abort
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int cnt;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    always #5 clk = ~clk;

    // requesters must hold req until granted
    assert property (@(posedge clk) disable iff (!rst_n) (b.if_req && !b.if_gnt) |=> b.if_req);
    assert property (@(posedge clk) disable iff (!rst_n) (b.ls_req && !b.ls_gnt) |=> b.ls_req);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b.if_req = 0; b.if_addr = 0;
        b.ls_req = 0; b.ls_we = 0; b.ls_be = 0; b.ls_addr = 0; b.ls_wdata = 0;
        b.mem_ready = 0; b.mem_rdata = 0;
        nxt(); nxt();
        rst_n = 1;
        #1;
        chk("rst mem_req", b.mem_req, 0);
        chk("rst if_rvalid", b.if_rvalid, 0);
        chk("rst ls_rvalid", b.ls_rvalid, 0);
        chk("rst mem_addr", b.mem_addr, 0);
        chk("rst gnts", {b.if_gnt, b.ls_gnt}, 0);

        // single IF fetch, memory ready two cycles after mem_req
        nxt(); b.if_req = 1; b.if_addr = 32'h100; #1;
        chk("t1 if_gnt", b.if_gnt, 1);
        chk("t1 ls_gnt", b.ls_gnt, 0);
        nxt(); b.if_req = 0; #1;
        chk("t1 mem_req", b.mem_req, 1);
        chk("t1 mem_addr", b.mem_addr, 32'h100);
        chk("t1 mem_we", b.mem_we, 0);
        chk("t1 mem_be", b.mem_be, 4'hF);
        chk("t1 mem_wdata", b.mem_wdata, 0);
        chk("t1 if_gnt pulse", b.if_gnt, 0);
        nxt(); #1;
        chk("t1 mem_req hold", b.mem_req, 1);
        chk("t1 early rvalid", b.if_rvalid, 0);
        nxt(); b.mem_ready = 1; b.mem_rdata = 32'h00500093; #1;
        chk("t1 mem_req t3", b.mem_req, 1);
        nxt(); b.mem_ready = 0; #1;
        chk("t1 if_rvalid", b.if_rvalid, 1);
        chk("t1 if_rdata", b.if_rdata, 32'h00500093);
        chk("t1 if_err", b.if_err, 0);
        chk("t1 mem_req drop", b.mem_req, 0);
        nxt(); #1;
        chk("t1 rvalid pulse", b.if_rvalid, 0);
        chk("t1 rdata hold", b.if_rdata, 32'h00500093);

        // simultaneous requests: LS store first, IF back-to-back on completion
        nxt();
        b.if_req = 1; b.if_addr = 32'h104;
        b.ls_req = 1; b.ls_we = 1; b.ls_addr = 32'h2000; b.ls_wdata = 32'hDEADBEEF; b.ls_be = 4'hF;
        b.mem_ready = 1; b.mem_rdata = 32'h11111111;
        #1;
        chk("t2 ls_gnt", b.ls_gnt, 1);
        chk("t2 if_gnt", b.if_gnt, 0);
        nxt(); b.ls_req = 0; #1;
        chk("t2 mem_we", b.mem_we, 1);
        chk("t2 mem_addr", b.mem_addr, 32'h2000);
        chk("t2 mem_wdata", b.mem_wdata, 32'hDEADBEEF);
        chk("t2 mem_be", b.mem_be, 4'hF);
        chk("t2 if_gnt b2b", b.if_gnt, 1);
        nxt(); b.if_req = 0; #1;
        chk("t2 ls_rvalid", b.ls_rvalid, 1);
        chk("t2 ls_rdata", b.ls_rdata, 0);
        chk("t2 ls_err", b.ls_err, 0);
        chk("t2 if_rvalid early", b.if_rvalid, 0);
        chk("t2 mem_req b2b", b.mem_req, 1);
        chk("t2 mem_addr if", b.mem_addr, 32'h104);
        chk("t2 mem_we if", b.mem_we, 0);
        nxt(); b.mem_ready = 0; #1;
        chk("t2 if_rvalid", b.if_rvalid, 1);
        chk("t2 if_rdata", b.if_rdata, 32'h11111111);
        chk("t2 ls_rvalid pulse", b.ls_rvalid, 0);
        chk("t2 mem_req drop", b.mem_req, 0);

        // both continuously requesting: LS,LS,LS,IF repeating
        nxt();
        b.if_req = 1; b.if_addr = 32'h180;
        b.ls_req = 1; b.ls_we = 0; b.ls_addr = 32'h3000;
        b.mem_ready = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t3 order %0d", i), {b.if_gnt, b.ls_gnt}, (i % 4 == 3) ? 2'b10 : 2'b01);
            nxt();
        end
        b.if_req = 0; #1;
        chk("t3 ls after if", b.ls_gnt, 1);
        nxt(); b.ls_req = 0; #1;
        chk("t3 ls_rdata", b.ls_rdata, 32'h11111111);
        nxt(); b.mem_ready = 0; #1;
        chk("t3 idle", b.mem_req, 0);

        // timeout on LS load
        nxt(); b.ls_req = 1; b.ls_we = 0; b.ls_addr = 32'h40; #1;
        chk("t4 ls_gnt", b.ls_gnt, 1);
        nxt(); b.ls_req = 0; #1;
        cnt = 0;
        while (b.mem_req && cnt < 40) begin
            cnt++;
            if (cnt == 16) chk("t4 addr hold", b.mem_addr, 32'h40);
            nxt();
        end
        chk("t4 busy cycles", cnt, 16);
        chk("t4 ls_rvalid", b.ls_rvalid, 1);
        chk("t4 ls_err", b.ls_err, 1);
        chk("t4 ls_rdata", b.ls_rdata, 0);
        nxt(); b.if_req = 1; b.if_addr = 32'h200; #1;
        chk("t4 err pulse", b.ls_err, 0);
        chk("t4 next gnt", b.if_gnt, 1);
        nxt(); b.if_req = 0; b.mem_ready = 1; b.mem_rdata = 32'hCAFE0001; #1;
        nxt(); b.mem_ready = 0; #1;
        chk("t4 next rvalid", b.if_rvalid, 1);
        chk("t4 next rdata", b.if_rdata, 32'hCAFE0001);
        chk("t4 next err", b.if_err, 0);

        // mem_ready on the exact timeout cycle completes normally
        nxt(); b.if_req = 1; b.if_addr = 32'h300; #1;
        chk("t5 gnt", b.if_gnt, 1);
        nxt(); b.if_req = 0;
        repeat (15) nxt();
        b.mem_ready = 1; b.mem_rdata = 32'hABCD1234; #1;
        chk("t5 mem_req at limit", b.mem_req, 1);
        nxt(); b.mem_ready = 0; #1;
        chk("t5 rvalid", b.if_rvalid, 1);
        chk("t5 err", b.if_err, 0);
        chk("t5 rdata", b.if_rdata, 32'hABCD1234);

        // reset mid-BUSY aborts silently
        nxt(); b.if_req = 1; b.if_addr = 32'h400; #1;
        chk("t6 gnt", b.if_gnt, 1);
        nxt(); b.if_req = 0;
        nxt();
        nxt(); rst_n = 0;
        nxt(); rst_n = 1; #1;
        chk("t6 mem_req", b.mem_req, 0);
        chk("t6 mem_addr", b.mem_addr, 0);
        chk("t6 if_rvalid", b.if_rvalid, 0);
        chk("t6 if_rdata", b.if_rdata, 0);
        b.if_req = 1; b.if_addr = 32'h500; #1;
        chk("t6 regrant", b.if_gnt, 1);
        nxt(); b.if_req = 0; b.mem_ready = 1; b.mem_rdata = 32'h00000513; #1;
        chk("t6 no stale rvalid", b.if_rvalid, 0);
        chk("t6 mem_addr new", b.mem_addr, 32'h500);
        nxt(); b.mem_ready = 0; #1;
        chk("t6 rvalid", b.if_rvalid, 1);
        chk("t6 rdata", b.if_rdata, 32'h00000513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
